// File: rtl/cdb_arbiter.sv
// cdb_arbiter: dual-channel common data bus arbiter.
// Six execution-unit sources compete for two CDB channels each cycle under a
// fixed priority (mult1, mult2, memory1, memory2, adder1, adder2). The top two
// ready sources are granted combinationally. Their results are registered onto
// channel 1 (winner A) and channel 2 (winner B) for broadcast on the next cycle.
module cdb_arbiter #(
  parameter  int PRF_SIZE = 64,
  parameter  int ROB_SIZE = 16,
  localparam int TW       = $clog2(PRF_SIZE),
  localparam int RW       = $clog2(ROB_SIZE) + 1,
  localparam int DW       = 64
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          adder1_result_ready,
  input  logic [DW-1:0] adder1_result_in,
  input  logic [TW-1:0] adder1_dest_reg_idx,
  input  logic [RW-1:0] adder1_rob_idx,
  input  logic          adder1_branch_taken,
  output logic          adder1_send_in_success,

  input  logic          mult1_result_ready,
  input  logic [DW-1:0] mult1_result_in,
  input  logic [TW-1:0] mult1_dest_reg_idx,
  input  logic [RW-1:0] mult1_rob_idx,
  output logic          mult1_send_in_success,

  input  logic          memory1_result_ready,
  input  logic [DW-1:0] memory1_result_in,
  input  logic [TW-1:0] memory1_dest_reg_idx,
  input  logic [RW-1:0] memory1_rob_idx,
  output logic          memory1_send_in_success,

  input  logic          adder2_result_ready,
  input  logic [DW-1:0] adder2_result_in,
  input  logic [TW-1:0] adder2_dest_reg_idx,
  input  logic [RW-1:0] adder2_rob_idx,
  input  logic          adder2_branch_taken,
  output logic          adder2_send_in_success,

  input  logic          mult2_result_ready,
  input  logic [DW-1:0] mult2_result_in,
  input  logic [TW-1:0] mult2_dest_reg_idx,
  input  logic [RW-1:0] mult2_rob_idx,
  output logic          mult2_send_in_success,

  input  logic          memory2_result_ready,
  input  logic [DW-1:0] memory2_result_in,
  input  logic [TW-1:0] memory2_dest_reg_idx,
  input  logic [RW-1:0] memory2_rob_idx,
  output logic          memory2_send_in_success,

  output logic          cdb1_valid,
  output logic [TW-1:0] cdb1_tag,
  output logic [DW-1:0] cdb1_out,
  output logic          cdb1_branch_is_taken,
  output logic [RW-1:0] cdb1_rob_idx,

  output logic          cdb2_valid,
  output logic [TW-1:0] cdb2_tag,
  output logic [DW-1:0] cdb2_out,
  output logic          cdb2_branch_is_taken,
  output logic [RW-1:0] cdb2_rob_idx
);

  localparam int NSRC = 6;

  // Slot numbers are the priority order: slot 0 wins over every other slot.
  localparam logic [2:0] SLOT_MULT1   = 3'd0;
  localparam logic [2:0] SLOT_MULT2   = 3'd1;
  localparam logic [2:0] SLOT_MEMORY1 = 3'd2;
  localparam logic [2:0] SLOT_MEMORY2 = 3'd3;
  localparam logic [2:0] SLOT_ADDER1  = 3'd4;
  localparam logic [2:0] SLOT_ADDER2  = 3'd5;

  logic [NSRC-1:0] src_ready;
  logic [DW-1:0]   src_value  [NSRC];
  logic [TW-1:0]   src_tag    [NSRC];
  logic [RW-1:0]   src_rob    [NSRC];
  logic [NSRC-1:0] src_branch;

  logic            win_a_vld;
  logic [2:0]      win_a;
  logic            win_b_vld;
  logic [2:0]      win_b;
  logic [NSRC-1:0] grant;

  // Gather the six sources into priority-ordered slots.
  always_comb begin
    src_ready[SLOT_MULT1]   = mult1_result_ready;
    src_ready[SLOT_MULT2]   = mult2_result_ready;
    src_ready[SLOT_MEMORY1] = memory1_result_ready;
    src_ready[SLOT_MEMORY2] = memory2_result_ready;
    src_ready[SLOT_ADDER1]  = adder1_result_ready;
    src_ready[SLOT_ADDER2]  = adder2_result_ready;

    src_value[SLOT_MULT1]   = mult1_result_in;
    src_value[SLOT_MULT2]   = mult2_result_in;
    src_value[SLOT_MEMORY1] = memory1_result_in;
    src_value[SLOT_MEMORY2] = memory2_result_in;
    src_value[SLOT_ADDER1]  = adder1_result_in;
    src_value[SLOT_ADDER2]  = adder2_result_in;

    src_tag[SLOT_MULT1]     = mult1_dest_reg_idx;
    src_tag[SLOT_MULT2]     = mult2_dest_reg_idx;
    src_tag[SLOT_MEMORY1]   = memory1_dest_reg_idx;
    src_tag[SLOT_MEMORY2]   = memory2_dest_reg_idx;
    src_tag[SLOT_ADDER1]    = adder1_dest_reg_idx;
    src_tag[SLOT_ADDER2]    = adder2_dest_reg_idx;

    src_rob[SLOT_MULT1]     = mult1_rob_idx;
    src_rob[SLOT_MULT2]     = mult2_rob_idx;
    src_rob[SLOT_MEMORY1]   = memory1_rob_idx;
    src_rob[SLOT_MEMORY2]   = memory2_rob_idx;
    src_rob[SLOT_ADDER1]    = adder1_rob_idx;
    src_rob[SLOT_ADDER2]    = adder2_rob_idx;

    // Only the adders resolve branches; every other unit reports not-taken.
    src_branch              = '0;
    src_branch[SLOT_ADDER1] = adder1_branch_taken;
    src_branch[SLOT_ADDER2] = adder2_branch_taken;
  end

  // Pick the first and second ready slots; reset suppresses all winners so
  // pending sources keep holding their results.
  always_comb begin
    win_a_vld = 1'b0;
    win_a     = '0;
    win_b_vld = 1'b0;
    win_b     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_ready[i] && !reset) begin
        if (!win_a_vld) begin
          win_a_vld = 1'b1;
          win_a     = 3'(i);
        end else if (!win_b_vld) begin
          win_b_vld = 1'b1;
          win_b     = 3'(i);
        end
      end
    end
  end

  // One-hot-per-winner grant vector in slot order.
  always_comb begin
    grant = '0;
    if (win_a_vld) grant[win_a] = 1'b1;
    if (win_b_vld) grant[win_b] = 1'b1;
  end

  assign mult1_send_in_success   = grant[SLOT_MULT1];
  assign mult2_send_in_success   = grant[SLOT_MULT2];
  assign memory1_send_in_success = grant[SLOT_MEMORY1];
  assign memory2_send_in_success = grant[SLOT_MEMORY2];
  assign adder1_send_in_success  = grant[SLOT_ADDER1];
  assign adder2_send_in_success  = grant[SLOT_ADDER2];

  // Channel 1 register: winner A, or all-zero when there is no winner.
  always_ff @(posedge clock) begin
    if (reset || !win_a_vld) begin
      cdb1_valid           <= 1'b0;
      cdb1_tag             <= '0;
      cdb1_out             <= '0;
      cdb1_branch_is_taken <= 1'b0;
      cdb1_rob_idx         <= '0;
    end else begin
      cdb1_valid           <= 1'b1;
      cdb1_tag             <= src_tag[win_a];
      cdb1_out             <= src_value[win_a];
      cdb1_branch_is_taken <= src_branch[win_a];
      cdb1_rob_idx         <= src_rob[win_a];
    end
  end

  // Channel 2 register: winner B. B only exists when A exists, so channel 2
  // can never be valid without channel 1.
  always_ff @(posedge clock) begin
    if (reset || !win_b_vld) begin
      cdb2_valid           <= 1'b0;
      cdb2_tag             <= '0;
      cdb2_out             <= '0;
      cdb2_branch_is_taken <= 1'b0;
      cdb2_rob_idx         <= '0;
    end else begin
      cdb2_valid           <= 1'b1;
      cdb2_tag             <= src_tag[win_b];
      cdb2_out             <= src_value[win_b];
      cdb2_branch_is_taken <= src_branch[win_b];
      cdb2_rob_idx         <= src_rob[win_b];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with a priority-list model
// and literal expectations from hand-worked scenarios.
module tb_cdb_arbiter;

  // Source numbering in the bench: 0 adder1, 1 mult1, 2 memory1,
  // 3 adder2, 4 mult2, 5 memory2.
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rdy [6];
  logic [63:0] val [6];
  logic [5:0]  tag [6];
  logic [4:0]  rob [6];
  logic        br1, br2;

  logic        g_add1, g_mul1, g_mem1, g_add2, g_mul2, g_mem2;
  logic        c1_v, c1_b, c2_v, c2_b;
  logic [5:0]  c1_t, c2_t;
  logic [63:0] c1_o, c2_o;
  logic [4:0]  c1_r, c2_r;

  wire [76:0]  c1_dut = {c1_v, c1_t, c1_o, c1_b, c1_r};
  wire [76:0]  c2_dut = {c2_v, c2_t, c2_o, c2_b, c2_r};

  int          errors = 0;
  int          checks = 0;
  logic [5:0]  g_seen;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock(clock), .reset(reset),
    .adder1_result_ready(rdy[0]), .adder1_result_in(val[0]),
    .adder1_dest_reg_idx(tag[0]), .adder1_rob_idx(rob[0]),
    .adder1_branch_taken(br1), .adder1_send_in_success(g_add1),
    .mult1_result_ready(rdy[1]), .mult1_result_in(val[1]),
    .mult1_dest_reg_idx(tag[1]), .mult1_rob_idx(rob[1]),
    .mult1_send_in_success(g_mul1),
    .memory1_result_ready(rdy[2]), .memory1_result_in(val[2]),
    .memory1_dest_reg_idx(tag[2]), .memory1_rob_idx(rob[2]),
    .memory1_send_in_success(g_mem1),
    .adder2_result_ready(rdy[3]), .adder2_result_in(val[3]),
    .adder2_dest_reg_idx(tag[3]), .adder2_rob_idx(rob[3]),
    .adder2_branch_taken(br2), .adder2_send_in_success(g_add2),
    .mult2_result_ready(rdy[4]), .mult2_result_in(val[4]),
    .mult2_dest_reg_idx(tag[4]), .mult2_rob_idx(rob[4]),
    .mult2_send_in_success(g_mul2),
    .memory2_result_ready(rdy[5]), .memory2_result_in(val[5]),
    .memory2_dest_reg_idx(tag[5]), .memory2_rob_idx(rob[5]),
    .memory2_send_in_success(g_mem2),
    .cdb1_valid(c1_v), .cdb1_tag(c1_t), .cdb1_out(c1_o),
    .cdb1_branch_is_taken(c1_b), .cdb1_rob_idx(c1_r),
    .cdb2_valid(c2_v), .cdb2_tag(c2_t), .cdb2_out(c2_o),
    .cdb2_branch_is_taken(c2_b), .cdb2_rob_idx(c2_r)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: walk the priority list, the first two ready sources win.
  function automatic logic [76:0] entry(input int p);
    logic b;
    b = (p == 0) ? br1 : (p == 3) ? br2 : 1'b0;
    return {1'b1, tag[p], val[p], b, rob[p]};
  endfunction

  task automatic model(input logic rst_v, output logic [5:0] eg,
                       output logic [76:0] e1, output logic [76:0] e2);
    int prio [6] = '{1, 4, 2, 5, 0, 3};
    int wa = -1;
    int wb = -1;
    for (int k = 0; k < 6; k++) begin
      if (!rst_v && rdy[prio[k]]) begin
        if (wa < 0) wa = prio[k];
        else if (wb < 0) wb = prio[k];
      end
    end
    eg = '0;
    e1 = '0;
    e2 = '0;
    if (wa >= 0) begin eg[wa] = 1'b1; e1 = entry(wa); end
    if (wb >= 0) begin eg[wb] = 1'b1; e2 = entry(wb); end
  endtask

  // One cycle: apply reset level, check grants mid-cycle, check CDB after the edge.
  task automatic step(input logic rst_v);
    logic [5:0]  eg;
    logic [76:0] e1, e2;
    @(negedge clock);
    reset = rst_v;
    #1;
    model(rst_v, eg, e1, e2);
    g_seen = {g_mem2, g_mul2, g_add2, g_mem1, g_mul1, g_add1};
    chk("grant", g_seen, eg);
    @(posedge clock);
    #1;
    chk("cdb1", c1_dut, e1);
    chk("cdb2", c2_dut, e2);
  endtask

  task automatic set_src(input int i, input logic [63:0] v, input logic [5:0] t,
                         input logic [4:0] r);
    rdy[i] = 1'b1;
    val[i] = v;
    tag[i] = t;
    rob[i] = r;
  endtask

  task automatic clear_ready();
    for (int i = 0; i < 6; i++) rdy[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] masks [6];
    masks = '{6'b111000, 6'b000111, 6'b101101, 6'b010010, 6'b100001, 6'b001100};
    for (int i = 0; i < 6; i++) begin
      set_src(i, 64'(100 + i), 6'(10 + i), 5'(i + 1));
    end
    br1 = 1'b1;
    br2 = 1'b1;

    // Reset with everything ready.
    step(1'b1);
    step(1'b1);
    chk("rst_grant", g_seen, 6'b0);
    chk("rst_cdb1", c1_dut, 77'd0);
    chk("rst_cdb2", c2_dut, 77'd0);

    // adder1 + mult2.
    clear_ready();
    set_src(0, 64'd5, 6'b000001, 5'b00101); br1 = 1'b1;
    set_src(4, 64'd7, 6'b000010, 5'b00001);
    step(1'b0);
    chk("a_grant", g_seen, 6'b010001);
    chk("a_cdb1", c1_dut, {1'b1, 6'b000010, 64'd7, 1'b0, 5'b00001});
    chk("a_cdb2", c2_dut, {1'b1, 6'b000001, 64'd5, 1'b1, 5'b00101});

    // mult1, adder2, memory2.
    clear_ready();
    set_src(1, 64'd45, 6'b110110, 5'b00010);
    set_src(3, 64'd67, 6'b100000, 5'b00100); br2 = 1'b1;
    set_src(5, 64'd4, 6'd8, 5'b00111);
    step(1'b0);
    chk("b_grant", g_seen, 6'b100010);
    chk("b_cdb1", c1_dut, {1'b1, 6'b110110, 64'd45, 1'b0, 5'b00010});
    chk("b_cdb2", c2_dut, {1'b1, 6'd8, 64'd4, 1'b0, 5'b00111});

    // Add memory1.
    set_src(2, 64'd4, 6'b110111, 5'b00000);
    step(1'b0);
    chk("c_grant", g_seen, 6'b000110);
    chk("c_tag1", c1_t, 6'b110110);
    chk("c_tag2", c2_t, 6'b110111);

    // All six ready, then nothing ready.
    rdy[0] = 1'b1;
    rdy[4] = 1'b1;
    step(1'b0);
    chk("d_grant", g_seen, 6'b010010);
    chk("d_tag1", c1_t, 6'b110110);
    chk("d_tag2", c2_t, 6'b000010);
    clear_ready();
    step(1'b0);
    chk("e_grant", g_seen, 6'b0);
    chk("e_cdb1", c1_dut, 77'd0);
    chk("e_cdb2", c2_dut, 77'd0);

    // Only adder2, branch taken.
    rdy[3] = 1'b1;
    br2 = 1'b1;
    step(1'b0);
    chk("f_grant", g_seen, 6'b001000);
    chk("f_cdb1", c1_dut, {1'b1, 6'b100000, 64'd67, 1'b1, 5'b00100});
    chk("f_v2", c2_v, 1'b0);

    // Reset mid-operation with sources pending; they win once reset drops.
    for (int i = 0; i < 6; i++) rdy[i] = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("g_grant", g_seen, 6'b0);
    chk("g_cdb1", c1_dut, 77'd0);
    step(1'b0);
    chk("h_grant", g_seen, 6'b010010);

    // Further ready patterns checked against the model only.
    br1 = 1'b0;
    for (int m = 0; m < 6; m++) begin
      for (int i = 0; i < 6; i++) rdy[i] = masks[m][i];
      step(1'b0);
    end
    br1 = 1'b1;
    for (int m = 0; m < 6; m++) begin
      for (int i = 0; i < 6; i++) rdy[i] = ~masks[m][i];
      step(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
